// File: rtl/ifid_queue.sv
// ---------------------------------------------------------------------------
// ifid_queue
//   Elastic IF/ID pipeline boundary. Replaces the single-entry IF/ID latch
//   with a DEPTH-entry circular queue of {pc, instruction, kill tag}. Decode
//   sees the head entry already split into MIPS fields.
//
//   All state updates on the FALLING edge of clk; reset is asynchronous and
//   active-low.
//
// Handshake (fetch side and decode side):
//   An entry moves from fetch into the queue on a falling edge where
//   if_valid & if_ready & ~flush. if_ready is a function of registered
//   occupancy only (no path from loaduse or flush). An entry leaves the
//   queue on a falling edge where id_valid & ~loaduse & ~flush. flush wins
//   over everything and empties the queue.
//
// Ports:
//   clk, rst_n         clock (falling-edge active), async active-low reset
//   if_valid/if_ready  fetch handshake
//   if_pc/if_instr/if_kill  entry presented by fetch
//   loaduse            decode hold: head is not consumed
//   flush              discard all queued entries
//   id_valid           head entry present
//   id_pc, id_kill     head pc and kill tag (0 when empty)
//   op_id..target_id   head instruction fields (0 when empty)
//   count              occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ifid_queue #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [PC_W-1:0]  if_pc,
  input  logic [31:0]      if_instr,
  input  logic             if_kill,
  input  logic             loaduse,
  input  logic             flush,
  output logic             id_valid,
  output logic [PC_W-1:0]  id_pc,
  output logic             id_kill,
  output logic [5:0]       op_id,
  output logic [4:0]       rs_id,
  output logic [4:0]       rt_id,
  output logic [4:0]       rd_id,
  output logic [4:0]       shamt_id,
  output logic [5:0]       func_id,
  output logic [15:0]      imm16_id,
  output logic [25:0]      target_id,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  // DEPTH is a power of two, so pointers wrap naturally at DEPTH-1 -> 0.
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [CNT_W-1:0] cnt;

  logic [PC_W-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic             kill_mem  [DEPTH];

  logic push;
  logic pop;

  assign count    = cnt;
  assign if_ready = (cnt != CNT_W'(DEPTH));
  assign id_valid = (cnt != '0);

  assign push = if_valid & if_ready & ~flush;
  assign pop  = id_valid & ~loaduse & ~flush;

  // Pointer and occupancy state.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(negedge clk) begin
    if (push) begin
      pc_mem[wp]    <= if_pc;
      instr_mem[wp] <= if_instr;
      kill_mem[wp]  <= if_kill;
    end
  end

  // Head entry, forced to an all-zero NOP when the queue is empty.
  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;
  logic            head_kill;

  assign head_instr = id_valid ? instr_mem[rp] : '0;
  assign head_pc    = id_valid ? pc_mem[rp]    : '0;
  assign head_kill  = id_valid ? kill_mem[rp]  : 1'b0;

  assign id_pc   = head_pc;
  assign id_kill = head_kill;

  // Overlapping field views of the same instruction word.
  assign op_id     = head_instr[31:26];
  assign rs_id     = head_instr[25:21];
  assign rt_id     = head_instr[20:16];
  assign rd_id     = head_instr[15:11];
  assign shamt_id  = head_instr[10:6];
  assign func_id   = head_instr[5:0];
  assign imm16_id  = head_instr[15:0];
  assign target_id = head_instr[25:0];

endmodule

// File: tb/tb_ifid_queue.sv
module tb_ifid_queue;

  localparam int PC_W  = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             if_valid;
  logic             if_ready;
  logic [PC_W-1:0]  if_pc;
  logic [31:0]      if_instr;
  logic             if_kill;
  logic             loaduse;
  logic             flush;
  logic             id_valid;
  logic [PC_W-1:0]  id_pc;
  logic             id_kill;
  logic [5:0]       op_id;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic [4:0]       rd_id;
  logic [4:0]       shamt_id;
  logic [5:0]       func_id;
  logic [15:0]      imm16_id;
  logic [25:0]      target_id;
  logic [CNT_W-1:0] count;

  ifid_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .if_kill(if_kill),
    .loaduse(loaduse), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_kill(id_kill),
    .op_id(op_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .shamt_id(shamt_id), .func_id(func_id), .imm16_id(imm16_id),
    .target_id(target_id), .count(count)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The queue contents as a plain FIFO of {pc, instr, kill} words.
  logic [64:0] exp_q[$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = if_valid && (exp_q.size() < DEPTH);
      do_pop  = (exp_q.size() > 0) && !loaduse;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({if_pc, if_instr, if_kill});
    end
  end

  // One compare process: outputs only change on the falling edge or on
  // reset, so they are sampled on the rising edge.
  always @(posedge clk) begin
    if (cmp_en) begin
      logic [31:0] ei;
      logic [31:0] ep;
      logic        ek;
      if (exp_q.size() > 0) {ep, ei, ek} = exp_q[0];
      else begin ep = '0; ei = '0; ek = 1'b0; end
      chk("cyc_count",    count,     exp_q.size());
      chk("cyc_id_valid", id_valid,  exp_q.size() != 0);
      chk("cyc_if_ready", if_ready,  exp_q.size() != DEPTH);
      chk("cyc_id_pc",    id_pc,     ep);
      chk("cyc_id_kill",  id_kill,   ek);
      chk("cyc_op",       op_id,     ei[31:26]);
      chk("cyc_rs",       rs_id,     ei[25:21]);
      chk("cyc_rt",       rt_id,     ei[20:16]);
      chk("cyc_rd",       rd_id,     ei[15:11]);
      chk("cyc_shamt",    shamt_id,  ei[10:6]);
      chk("cyc_func",     func_id,   ei[5:0]);
      chk("cyc_imm16",    imm16_id,  ei[15:0]);
      chk("cyc_target",   target_id, ei[25:0]);
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; the falling edge in
  // between commits them.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit k, input bit lu, input bit fl);
    if_valid = v; if_pc = pc; if_instr = ins; if_kill = k;
    loaduse = lu; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_id_valid", id_valid, 0);
    chk("rst_if_ready", if_ready, 1);
    chk("rst_count",    count,    0);
    chk("rst_id_pc",    id_pc,    0);
    rst_n = 1'b1;

    // Load word after reset.
    drive(1'b1, 32'h3000, 32'h8C22_0004, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("lw_id_valid", id_valid, 1);
    chk("lw_op",       op_id,    6'h23);
    chk("lw_rs",       rs_id,    5'd1);
    chk("lw_rt",       rt_id,    5'd2);
    chk("lw_imm16",    imm16_id, 16'h0004);
    chk("lw_count",    count,    1);
    chk("lw_pc",       id_pc,    32'h3000);
    tick();
    chk("lw_drained", count, 0);

    // Three pushes under loaduse: the third is refused.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h0100_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("full_count",    count,    2);
    chk("full_if_ready", if_ready, 0);
    chk("full_head_pc",  id_pc,    32'h100);
    idle();
    tick();
    chk("drain1_pc",    id_pc, 32'h104);
    chk("drain1_count", count, 1);
    tick();
    chk("drain2_count", count, 0);

    // Streaming push+pop at occupancy 1; pointers wrap several times.
    drive(1'b1, 32'h200, 32'h2000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
      tick();
      chk("stream_count", count, 1);
      chk("stream_pc",    id_pc, 32'h200 + 32'(4 * i));
    end
    idle();
    tick();
    chk("stream_end", count, 0);

    // Full queue held by loaduse, then flush with fetch still pushing.
    drive(1'b1, 32'h300, 32'h0000_0020, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h304, 32'h0000_0022, 1'b0, 1'b1, 1'b0); tick();
    chk("pre_flush_count", count, 2);
    drive(1'b1, 32'h308, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    tick();
    chk("flush_count",    count,     0);
    chk("flush_id_valid", id_valid,  0);
    chk("flush_if_ready", if_ready,  1);
    chk("flush_pc",       id_pc,     0);
    chk("flush_func",     func_id,   0);
    idle();
    tick();
    chk("flush_dropped", count, 0);

    // Killed jump is queued and popped like any other entry.
    drive(1'b1, 32'h400, 32'h0800_0C00, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    chk("kill_tag",    id_kill,   1);
    chk("kill_op",     op_id,     6'h02);
    chk("kill_target", target_id, 26'h0000C00);
    tick();
    chk("kill_popped", count,   0);
    chk("kill_clear",  id_kill, 0);

    // Mixed pattern, checked by the model only.
    for (int i = 0; i < 24; i++) begin
      drive((i % 3) != 2, 32'h600 + 32'(4 * i), 32'h1234_5678 ^ 32'(i * 32'h0101_0101),
            i[0], (i % 5) < 2, i == 13);
      tick();
    end
    idle();

    // Asynchronous reset between edges with two entries queued.
    drive(1'b1, 32'h700, 32'h1111_1111, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h704, 32'h2222_2222, 1'b0, 1'b1, 1'b0); tick();
    idle();
    loaduse = 1'b1;
    chk("prerst_count", count, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count",    count,    0);
    chk("arst_id_valid", id_valid, 0);
    chk("arst_id_pc",    id_pc,    0);
    chk("arst_op",       op_id,    0);
    chk("arst_if_ready", if_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 32'h500, 32'h8C22_0004, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("post_rst_count", count, 1);
    chk("post_rst_pc",    id_pc, 32'h500);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Parametrised IF/ID pipeline boundary. It replaces the single-entry IF/ID latch with a DEPTH-entry elastic queue.
- Fetch pushes {pc, instruction, kill tag} under a valid/ready handshake.
- Decode sees the head entry pre-split into MIPS fields, and consumes it unless load-use hold is asserted.
- Adds valid tracking, flush and occupancy reporting. The single-entry latch had none of these.

Parameters:
PC_W, 32, width of program counter carried with each entry
DEPTH, 2, queue entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on the falling edge
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch presents an entry
if_ready  out  1  queue can accept an entry this cycle
if_pc  in  PC_W  pc of fetched instruction
if_instr  in  32  fetched instruction word
if_kill  in  1  entry is a bubble; decode must not execute it
loaduse  in  1  decode hold; head entry is not consumed
flush  in  1  discard all queued entries (branch/jump redirect)
id_valid  out  1  head entry present
id_pc  out  PC_W  pc of head entry
id_kill  out  1  kill tag of head entry
op_id  out  6  head instr[31:26]
rs_id  out  5  head instr[25:21]
rt_id  out  5  head instr[20:16]
rd_id  out  5  head instr[15:11]
shamt_id  out  5  head instr[10:6]
func_id  out  6  head instr[5:0]
imm16_id  out  16  head instr[15:0]
target_id  out  26  head instr[25:0]
count  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, instr, kill}, with write pointer wp, read pointer rp and count.
- Reset (rst_n low, asynchronous): wp=rp=0, count=0.
  - Consequently id_valid=0, if_ready=1, all decoded fields, id_pc and id_kill = 0.
  - Storage contents need no reset.
- if_ready = (count != DEPTH). It depends on registered state only; there is no combinational path from loaduse or flush.
- push = if_valid & if_ready & ~flush.
  - On the falling edge, the entry is written at wp and wp advances, wrapping DEPTH-1 -> 0.
- pop = id_valid & ~loaduse & ~flush.
  - On the falling edge, rp advances with the same wrap.
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Simultaneous push and pop:
  - Legal at any count < DEPTH, including count=0? No: pop requires id_valid, so at count=0 only the push occurs.
  - When count=DEPTH, push is blocked by if_ready, so occupancy never exceeds DEPTH.
- Latency: an entry pushed at edge N is visible on id_* after edge N when the queue was empty. There is no same-cycle bypass.
- Head outputs are combinational from the entry at rp, gated by id_valid. When count=0 every decoded field, id_pc and id_kill = 0, i.e. decode sees a NOP.
- id_valid = (count != 0).
- loaduse:
  - Freezes rp; head outputs hold stable for every cycle loaduse is high.
  - Pushes continue while space remains.
- flush:
  - Highest priority. On the falling edge: wp=rp=0, count=0.
  - Any concurrent push and pop are discarded.
  - loaduse is ignored in that cycle.
  - The next cycle shows id_valid=0 and if_ready=1.
- Kill tag is carried untouched. A killed entry is still queued and popped normally; it only marks the entry for decode to suppress.
- Reset asserted mid-operation clears immediately, asynchronously, regardless of clk. The first edge after deassertion behaves as from empty.
- Decoded fields overlap by design: rd/shamt/func and imm16 share bits, as do rs/rt/imm16 and target.

Test Plan:
- Reset then push pc=0x3000, instr=0x8C220004 -> after one falling edge:
  - id_valid=1, op_id=0x23, rs_id=1, rt_id=2, imm16_id=0x0004, count=1.
- Push 3 entries, DEPTH=2, loaduse=1 throughout -> count=2, if_ready=0, third entry not accepted, head pc unchanged. Release loaduse -> entries drain in order.
- Continuous push+pop at count=1 for 8 cycles -> count stays 1; id_pc follows input with one edge of delay; pointers wrap cleanly.
- Queue full with loaduse=1, assert flush with if_valid=1 -> next cycle count=0, id_valid=0, all fields 0, pushed entry dropped.
- Push instr=0x0800_0C00 with if_kill=1 -> id_kill=1, op_id=0x02, target_id=0x0000C00. Entry pops normally.
- Assert rst_n=0 between clock edges with count=2 -> outputs zero immediately, before the next edge.
